// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: stage bit indices, death FSM
// state encoding and default playfield geometry.
package hazard_pkg;

    localparam int ST_LEVEL_BEGIN   = 7;
    localparam int ST_INIT          = 6;
    localparam int ST_PIT_OPENING_1 = 5;
    localparam int ST_PIT_OPENED_1  = 4;
    localparam int ST_PIT_OPENING_2 = 3;
    localparam int ST_PIT_OPENED_2  = 2;
    localparam int ST_SPIKES        = 1;
    localparam int ST_SPIKES_OPENED = 0;

    typedef enum logic {
        ARMED = 1'b0,
        HOLD  = 1'b1
    } death_state_t;

    localparam int DEF_PIT1_X       = 200;
    localparam int DEF_PIT2_X       = 400;
    localparam int DEF_PIT_STEP     = 4;
    localparam int DEF_PIT_MAX      = 32;
    localparam int DEF_SPIKE_X0     = 500;
    localparam int DEF_SPIKE_X1     = 560;
    localparam int DEF_SPIKE_PERIOD = 30;
    localparam int DEF_FLOOR_Y      = 400;
    localparam int DEF_PLAYER_W     = 16;
    localparam int DEF_PLAYER_H     = 32;
    localparam int DEF_SCREEN_H     = 480;
    localparam int DEF_DEATH_HOLD   = 60;

    // Zero-extend a 10-bit screen coordinate so sums cannot overflow.
    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the level FSM / physics / renderer and hazard_ctrl.
// Lives and game_over exist only when HAZARD_LIVES_EN is defined.
interface hazard_ctrl_if;
    logic       frame_tick;
    logic [7:0] stage;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] pit1_w;
    logic [9:0] pit2_w;
    logic       pit1_done;
    logic       pit2_done;
    logic       spikes_up;
    logic       death;
    logic       death_active;
`ifdef HAZARD_LIVES_EN
    logic [1:0] lives;
    logic       game_over;

    modport master (
        output frame_tick, stage, player_x, player_y,
        input  pit1_w, pit2_w, pit1_done, pit2_done, spikes_up,
               death, death_active, lives, game_over
    );
    modport slave (
        input  frame_tick, stage, player_x, player_y,
        output pit1_w, pit2_w, pit1_done, pit2_done, spikes_up,
               death, death_active, lives, game_over
    );
`else
    modport master (
        output frame_tick, stage, player_x, player_y,
        input  pit1_w, pit2_w, pit1_done, pit2_done, spikes_up,
               death, death_active
    );
    modport slave (
        input  frame_tick, stage, player_x, player_y,
        output pit1_w, pit2_w, pit1_done, pit2_done, spikes_up,
               death, death_active
    );
`endif
endinterface

// File: rtl/hazard_ctrl_pit_animator.sv
// One pit: widens by STEP on each enabled tick, saturating at MAX; done is
// registered alongside the width so both change on the same edge.
module pit_animator #(
    parameter int STEP = 4,
    parameter int MAX  = 32,
    parameter int W    = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         open_en,
    input  logic         clear,
    output logic [W-1:0] w,
    output logic         done
);

    logic [W:0]   sum;
    logic [W-1:0] w_nxt;

    assign sum   = {1'b0, w} + (W+1)'(STEP);
    assign w_nxt = (sum >= (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w    <= '0;
            done <= 1'b0;
        end else if (clear) begin
            w    <= '0;
            done <= 1'b0;
        end else if (tick && open_en) begin
            w    <= w_nxt;
            done <= (w_nxt == W'(MAX));
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pit/spike animation, player collision detection and post-death hold-off.
// Define HAZARD_LIVES_EN to add the 3-life counter and sticky game_over.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int PIT1_X       = DEF_PIT1_X,
    parameter int PIT2_X       = DEF_PIT2_X,
    parameter int PIT_STEP     = DEF_PIT_STEP,
    parameter int PIT_MAX      = DEF_PIT_MAX,
    parameter int SPIKE_X0     = DEF_SPIKE_X0,
    parameter int SPIKE_X1     = DEF_SPIKE_X1,
    parameter int SPIKE_PERIOD = DEF_SPIKE_PERIOD,
    parameter int FLOOR_Y      = DEF_FLOOR_Y,
    parameter int PLAYER_W     = DEF_PLAYER_W,
    parameter int PLAYER_H     = DEF_PLAYER_H,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int DEATH_HOLD   = DEF_DEATH_HOLD
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam int SCW = $clog2(SPIKE_PERIOD + 1);
    localparam int HCW = $clog2(DEATH_HOLD + 1);

    logic lvl_begin;
    logic spike_en;
    logic unused_stage;

    assign lvl_begin    = hz.stage[ST_LEVEL_BEGIN];
    assign spike_en     = hz.stage[ST_SPIKES] | hz.stage[ST_SPIKES_OPENED];
    assign unused_stage = ^{hz.stage[ST_INIT], hz.stage[ST_PIT_OPENED_1],
                            hz.stage[ST_PIT_OPENED_2]};

    pit_animator #(.STEP(PIT_STEP), .MAX(PIT_MAX), .W(10)) u_pit1 (
        .clk     (clk),
        .reset   (reset),
        .tick    (hz.frame_tick),
        .open_en (hz.stage[ST_PIT_OPENING_1]),
        .clear   (lvl_begin),
        .w       (hz.pit1_w),
        .done    (hz.pit1_done)
    );

    pit_animator #(.STEP(PIT_STEP), .MAX(PIT_MAX), .W(10)) u_pit2 (
        .clk     (clk),
        .reset   (reset),
        .tick    (hz.frame_tick),
        .open_en (hz.stage[ST_PIT_OPENING_2]),
        .clear   (lvl_begin),
        .w       (hz.pit2_w),
        .done    (hz.pit2_done)
    );

    // Spike timer: free-running only while a spike stage is active.
    logic [SCW-1:0] spike_cnt;
    logic           spikes_up_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_cnt   <= '0;
            spikes_up_q <= 1'b0;
        end else if (lvl_begin || !spike_en) begin
            spike_cnt   <= '0;
            spikes_up_q <= 1'b0;
        end else if (hz.frame_tick) begin
            if (spike_cnt == SCW'(SPIKE_PERIOD - 1)) begin
                spike_cnt   <= '0;
                spikes_up_q <= ~spikes_up_q;
            end else begin
                spike_cnt <= spike_cnt + SCW'(1);
            end
        end
    end

    assign hz.spikes_up = spikes_up_q;

    // Collision: all geometry in 11 bits so x+W / y+H never wrap.
    logic [10:0] px, px_r, py, py_b;
    logic        grounded, pit1_hit, pit2_hit, spike_hit, fall_hit, hit;

    assign px   = ext11(hz.player_x);
    assign py   = ext11(hz.player_y);
    assign px_r = px + 11'(PLAYER_W);
    assign py_b = py + 11'(PLAYER_H);

    assign grounded  = (py_b >= 11'(FLOOR_Y));
    assign pit1_hit  = (hz.pit1_w != '0) && (px >= 11'(PIT1_X)) &&
                       (px_r <= 11'(PIT1_X) + ext11(hz.pit1_w)) && grounded;
    assign pit2_hit  = (hz.pit2_w != '0) && (px >= 11'(PIT2_X)) &&
                       (px_r <= 11'(PIT2_X) + ext11(hz.pit2_w)) && grounded;
    assign spike_hit = spikes_up_q && (px_r > 11'(SPIKE_X0)) &&
                       (px < 11'(SPIKE_X1)) && grounded;
    assign fall_hit  = (py >= 11'(SCREEN_H));
    assign hit       = pit1_hit | pit2_hit | spike_hit | fall_hit;

    // Death FSM
    death_state_t   state;
    logic [HCW-1:0] hold_cnt;
    logic           death_q;
    logic           death_active_q;
    logic           can_die;

`ifdef HAZARD_LIVES_EN
    logic [1:0] lives_q;
    logic       game_over_q;

    assign can_die      = ~game_over_q;
    assign hz.lives     = lives_q;
    assign hz.game_over = game_over_q;
`else
    assign can_die = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ARMED;
            hold_cnt       <= '0;
            death_q        <= 1'b0;
            death_active_q <= 1'b0;
`ifdef HAZARD_LIVES_EN
            lives_q        <= 2'd3;
            game_over_q    <= 1'b0;
`endif
        end else begin
            death_q <= 1'b0;
            case (state)
                ARMED: begin
                    if (hit && !lvl_begin && can_die) begin
                        state          <= HOLD;
                        hold_cnt       <= HCW'(DEATH_HOLD);
                        death_q        <= 1'b1;
                        death_active_q <= 1'b1;
`ifdef HAZARD_LIVES_EN
                        lives_q        <= lives_q - 2'd1;
                        if (lives_q == 2'd1)
                            game_over_q <= 1'b1;
`endif
                    end
                end
                HOLD: begin
                    // Leave on the tick that would bring the count to zero.
                    if (hz.frame_tick) begin
                        if (hold_cnt <= HCW'(1)) begin
                            state          <= ARMED;
                            hold_cnt       <= '0;
                            death_active_q <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - HCW'(1);
                        end
                    end
                end
                default: begin
                    state          <= ARMED;
                    hold_cnt       <= '0;
                    death_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign hz.death        = death_q;
    assign hz.death_active = death_active_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_w1, m_w2, m_cnt, m_hold, m_lives;
    bit m_up, m_go, m_death;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_w1 = 0; m_w2 = 0; m_cnt = 0; m_hold = 0;
        m_up = 0; m_go = 0; m_death = 0; m_lives = 3;
    endtask

    task automatic model_step(input logic [7:0] st, input bit ft, input int px, input int py);
        bit g, hit;
        g   = (py + 32 >= 400);
        hit = (m_w1 > 0 && px >= 200 && px + 16 <= 200 + m_w1 && g) ||
              (m_w2 > 0 && px >= 400 && px + 16 <= 400 + m_w2 && g) ||
              (m_up && px + 16 > 500 && px < 560 && g) ||
              (py >= 480);
        m_death = 0;
        if (m_hold > 0) begin
            if (ft) m_hold--;
        end else if (hit && !st[7] && !m_go) begin
            m_death = 1;
            m_hold  = 60;
`ifdef HAZARD_LIVES_EN
            m_lives--;
            if (m_lives == 0) m_go = 1;
`endif
        end
        if (st[7]) begin
            m_w1 = 0; m_w2 = 0;
        end else begin
            if (ft && st[5]) m_w1 = imin(m_w1 + 4, 32);
            if (ft && st[3]) m_w2 = imin(m_w2 + 4, 32);
        end
        if (st[7] || !(st[1] || st[0])) begin
            m_cnt = 0; m_up = 0;
        end else if (ft) begin
            m_cnt++;
            if (m_cnt == 30) begin
                m_cnt = 0;
                m_up  = !m_up;
            end
        end
    endtask

    task automatic check_all();
        chk("pit1_w",       hz.pit1_w,       m_w1);
        chk("pit2_w",       hz.pit2_w,       m_w2);
        chk("pit1_done",    hz.pit1_done,    m_w1 == 32);
        chk("pit2_done",    hz.pit2_done,    m_w2 == 32);
        chk("spikes_up",    hz.spikes_up,    m_up);
        chk("death",        hz.death,        m_death);
        chk("death_active", hz.death_active, m_hold > 0);
`ifdef HAZARD_LIVES_EN
        chk("lives",        hz.lives,        m_lives);
        chk("game_over",    hz.game_over,    m_go);
`endif
    endtask

    // Called at #1 after a rising edge; drives inputs, advances one cycle.
    task automatic step(input logic [7:0] st, input bit ft, input int px, input int py);
        hz.stage      = st;
        hz.frame_tick = ft;
        hz.player_x   = px[9:0];
        hz.player_y   = py[9:0];
        @(posedge clk);
        model_step(st, ft, px, py);
        #1;
        check_all();
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        logic [7:0] st;
        int px, py, k;
        bit ft;

        reset = 1'b1;
        hz.stage = '0; hz.frame_tick = 1'b0; hz.player_x = '0; hz.player_y = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // pit 1 opening, 10 ticks; pit 2 untouched
        for (int i = 1; i <= 10; i++) begin
            step(8'h20, 1'b1, 0, 0);
            chk("t2_w1", hz.pit1_w, imin(4 * i, 32));
            chk("t2_done", hz.pit1_done, i >= 8);
        end
        chk("t2_w2", hz.pit2_w, 0);

        // standing in open pit 1 -> single death, 60-tick hold, no re-trigger
        step(8'h10, 1'b0, 208, 368);
        chk("t3_death", hz.death, 1);
        chk("t3_active", hz.death_active, 1);
        for (int i = 1; i <= 60; i++) begin
            step(8'h10, 1'b1, 208, 368);
            chk("t3_nopulse", hz.death, 0);
            chk("t3_hold", hz.death_active, i < 60);
        end
        step(8'h10, 1'b0, 0, 0);
        chk("t3_rearm", hz.death, 0);

        // spikes toggle every 30 ticks; lethal only when up
        for (int i = 1; i <= 30; i++) step(8'h02, 1'b1, 0, 0);
        chk("t4_up", hz.spikes_up, 1);
        for (int i = 1; i <= 30; i++) step(8'h02, 1'b1, 0, 0);
        chk("t4_down", hz.spikes_up, 0);
        for (int i = 0; i < 5; i++) begin
            step(8'h02, 1'b0, 520, 368);
            chk("t4_safe", hz.death, 0);
        end
        for (int i = 1; i <= 30; i++) step(8'h02, 1'b1, 0, 0);
        step(8'h02, 1'b0, 520, 368);
        chk("t4_kill", hz.death, 1);
        for (int i = 0; i < 10; i++) step(8'h02, 1'b1, 0, 0);

        // async reset in the middle of a hold and a spike cycle
        #2;
        reset = 1'b1;
        #1;
        chk("t1_w1", hz.pit1_w, 0);
        chk("t1_w2", hz.pit2_w, 0);
        chk("t1_done", hz.pit1_done, 0);
        chk("t1_spk", hz.spikes_up, 0);
        chk("t1_death", hz.death, 0);
        chk("t1_active", hz.death_active, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // level_begin beats a same-cycle pit hit and clears widths
        for (int i = 0; i < 8; i++) step(8'h20, 1'b1, 0, 0);
        step(8'h80, 1'b0, 208, 368);
        chk("t5_death", hz.death, 0);
        chk("t5_w1", hz.pit1_w, 0);

`ifdef HAZARD_LIVES_EN
        for (int i = 0; i < 8; i++) step(8'h20, 1'b1, 0, 0);
        for (int d = 0; d < 4; d++) begin
            step(8'h10, 1'b0, 208, 368);
            chk("t6_death", hz.death, d < 3);
            chk("t6_lives", hz.lives, (d < 3) ? 2 - d : 0);
            for (int i = 0; i < 60; i++) step(8'h10, 1'b1, 0, 0);
        end
        chk("t6_over", hz.game_over, 1);
`endif

        // random phase
        sync_reset();
        st = 8'h00;
        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 699) sync_reset();
            if ($urandom % 16 == 0) begin
                k  = $urandom % 9;
                st = (k == 8) ? 8'h00 : 8'(1 << k);
            end
            ft = ($urandom % 3 == 0);
            case ($urandom % 4)
                0: px = 190 + $urandom % 40;
                1: px = 390 + $urandom % 40;
                2: px = 480 + $urandom % 100;
                default: px = $urandom % 1024;
            endcase
            case ($urandom % 4)
                0, 1: py = 360 + $urandom % 20;
                2: py = 470 + $urandom % 20;
                default: py = $urandom % 1024;
            endcase
            step(st, ft, px, py);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
